// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, drives the instruction ROM and loads the IF/ID register.
// Optional macro FETCH_ALIGN_CHECK_EN adds id_adel_o, flagging misaligned fetches for ID.
module inst_fetch #(
  parameter int unsigned      ADDR_W   = 32,
  parameter int unsigned      INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_if,
  input  logic              stall_id,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] new_pc_i,
  output logic              rom_ce_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [INST_W-1:0] rom_inst_i,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [INST_W-1:0] id_inst_o,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic              id_adel_o,
`endif
  output logic              id_valid_o
);

  logic              r_ce;
  logic [ADDR_W-1:0] r_pc;
  logic              r_pend_valid;
  logic [ADDR_W-1:0] r_pend_target;
  logic [ADDR_W-1:0] r_id_pc;
  logic [INST_W-1:0] r_id_inst;
  logic              r_id_valid;
  logic [INST_W-1:0] w_fetch_inst;

  assign rom_ce_o   = r_ce;
  assign rom_addr_o = r_pc;
  assign id_pc_o    = r_id_pc;
  assign id_inst_o  = r_id_inst;
  assign id_valid_o = r_id_valid;

`ifdef FETCH_ALIGN_CHECK_EN
  logic w_misalign;
  logic r_id_adel;
  assign w_misalign   = (r_pc[1:0] != 2'b00);
  // Misaligned fetches carry a zero word; ID sees valid+adel and raises AdEL.
  assign w_fetch_inst = (r_ce && !w_misalign) ? rom_inst_i : '0;
  assign id_adel_o    = r_id_adel;
`else
  assign w_fetch_inst = r_ce ? rom_inst_i : '0;
`endif

  // PC and pending redirect. A branch seen while IF is stalled is parked, not dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ce          <= 1'b0;
      r_pc          <= RESET_PC;
      r_pend_valid  <= 1'b0;
      r_pend_target <= '0;
    end else begin
      r_ce <= 1'b1;
      if (r_ce) begin
        if (flush_i) begin
          r_pc         <= new_pc_i;
          r_pend_valid <= 1'b0;
        end else if (stall_if) begin
          if (branch_flag_i) begin
            r_pend_valid  <= 1'b1;
            r_pend_target <= branch_target_i;
          end
        end else if (branch_flag_i) begin
          r_pc         <= branch_target_i;
          r_pend_valid <= 1'b0;
        end else if (r_pend_valid) begin
          r_pc         <= r_pend_target;
          r_pend_valid <= 1'b0;
        end else begin
          r_pc <= r_pc + ADDR_W'(4);
        end
      end
    end
  end

  // IF/ID register. The instruction in IF is never squashed by a branch (delay slot).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_id_pc    <= '0;
      r_id_inst  <= '0;
      r_id_valid <= 1'b0;
    end else if (flush_i) begin
      r_id_pc    <= '0;
      r_id_inst  <= '0;
      r_id_valid <= 1'b0;
    end else if (stall_id) begin
      r_id_pc    <= r_id_pc;
    end else if (stall_if) begin
      r_id_inst  <= '0;
      r_id_valid <= 1'b0;
    end else begin
      r_id_pc    <= r_pc;
      r_id_inst  <= w_fetch_inst;
      r_id_valid <= r_ce;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           r_id_adel <= 1'b0;
    else if (flush_i)   r_id_adel <= 1'b0;
    else if (stall_id)  r_id_adel <= r_id_adel;
    else if (stall_if)  r_id_adel <= 1'b0;
    else                r_id_adel <= r_ce & w_misalign;
  end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: the bench models the ROM and checks hand-derived PC/IF-ID values.
module tb_inst_fetch;
  logic        clk = 1'b0;
  logic        rst;
  logic        stall_if, stall_id, branch_flag_i, flush_i;
  logic [31:0] branch_target_i, new_pc_i;
  logic        rom_ce_o;
  logic [31:0] rom_addr_o, rom_inst_i, id_pc_o, id_inst_o;
  logic        id_valid_o;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        id_adel_o;
`endif

  int tests = 0;
  int fails = 0;

  inst_fetch dut (
    .clk(clk), .rst(rst), .stall_if(stall_if), .stall_id(stall_id),
    .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
    .flush_i(flush_i), .new_pc_i(new_pc_i),
    .rom_ce_o(rom_ce_o), .rom_addr_o(rom_addr_o), .rom_inst_i(rom_inst_i),
    .id_pc_o(id_pc_o), .id_inst_o(id_inst_o),
`ifdef FETCH_ALIGN_CHECK_EN
    .id_adel_o(id_adel_o),
`endif
    .id_valid_o(id_valid_o)
  );

  always #5 clk = ~clk;

  // ROM word: address-tagged pattern, zero when not enabled
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction
  assign rom_inst_i = rom_ce_o ? rom_word(rom_addr_o) : 32'h0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall_if = 0; stall_id = 0; branch_flag_i = 0; flush_i = 0;
    branch_target_i = 0; new_pc_i = 0;
  endtask

  task automatic chk_pc(input string name, input logic [31:0] exp);
    tests++;
    if (rom_addr_o !== exp) begin
      fails++; $display("FAIL %s rom_addr_o got %h exp %h", name, rom_addr_o, exp);
    end
  endtask

  task automatic chk_id(input string name, input logic [31:0] epc, input logic [31:0] einst, input logic ev);
    tests++;
    if (id_pc_o !== epc || id_inst_o !== einst || id_valid_o !== ev) begin
      fails++;
      $display("FAIL %s id pc/inst/valid got %h/%h/%b exp %h/%h/%b",
               name, id_pc_o, id_inst_o, id_valid_o, epc, einst, ev);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 0;
    #2;
    tests++;
    if (rom_ce_o !== 1'b0 || rom_addr_o !== 32'h0) begin
      fails++; $display("FAIL reset_rom ce/addr got %b/%h exp 0/0", rom_ce_o, rom_addr_o);
    end
    chk_id("reset_id", 32'h0, 32'h0, 1'b0);
`ifdef FETCH_ALIGN_CHECK_EN
    tests++;
    if (id_adel_o !== 1'b0) begin fails++; $display("FAIL reset_adel got %b exp 0", id_adel_o); end
`endif
    @(negedge clk); rst = 1;
  endtask

  task automatic test_seq_fetch();
    step();
    tests++;
    if (rom_ce_o !== 1'b1) begin fails++; $display("FAIL ce_rise got %b exp 1", rom_ce_o); end
    chk_pc("first_pc", 32'h0);
    chk_id("first_id_bubble", 32'h0, 32'h0, 1'b0);
    step(); chk_id("seq_0", 32'h0, rom_word(32'h0), 1'b1);
    step(); chk_id("seq_4", 32'h4, rom_word(32'h4), 1'b1);
    chk_pc("seq_pc8", 32'h8);
  endtask

  task automatic test_branch_delay_slot();
    branch_flag_i = 1; branch_target_i = 32'h40;
    step();
    branch_flag_i = 0;
    chk_pc("br_pc", 32'h40);
    chk_id("br_delay_slot", 32'h8, rom_word(32'h8), 1'b1);
    step();
    chk_id("br_target_id", 32'h40, rom_word(32'h40), 1'b1);
  endtask

  task automatic test_stall_pending();
    // pc = 0x44 here
    stall_if = 1; branch_flag_i = 1; branch_target_i = 32'h80;
    step();
    branch_flag_i = 0; branch_target_i = 0;
    chk_pc("stall_pc1", 32'h44);
    chk_id("stall_bubble1", 32'h40, 32'h0, 1'b0);
    step(); chk_pc("stall_pc2", 32'h44);
    step(); chk_pc("stall_pc3", 32'h44);
    chk_id("stall_bubble3", 32'h40, 32'h0, 1'b0);
    stall_if = 0;
    step();
    chk_pc("pend_redirect", 32'h80);
    chk_id("pend_delay_slot", 32'h44, rom_word(32'h44), 1'b1);
    step();
    chk_pc("pend_cleared", 32'h84);
  endtask

  task automatic test_flush();
    flush_i = 1; new_pc_i = 32'h180;
    branch_flag_i = 1; branch_target_i = 32'h200; stall_if = 1;
    step();
    idle_inputs();
    chk_pc("flush_pc", 32'h180);
    chk_id("flush_id", 32'h0, 32'h0, 1'b0);
    step();
    chk_pc("flush_no_pend", 32'h184);
    chk_id("flush_next_id", 32'h180, rom_word(32'h180), 1'b1);
  endtask

  task automatic test_wrap();
    flush_i = 1; new_pc_i = 32'hFFFF_FFFC;
    step();
    idle_inputs();
    chk_pc("wrap_pre", 32'hFFFF_FFFC);
    step();
    chk_pc("wrap_pc", 32'h0);
    chk_id("wrap_id", 32'hFFFF_FFFC, rom_word(32'hFFFF_FFFC), 1'b1);
    step();
    chk_pc("wrap_pc4", 32'h4);
  endtask

  task automatic test_reset_mid_stall();
    stall_if = 1; branch_flag_i = 1; branch_target_i = 32'h300;
    step();
    branch_flag_i = 0;
    chk_pc("rst_stall_hold", 32'h4);
    #2 rst = 0;
    #1;
    tests++;
    if (rom_ce_o !== 1'b0 || rom_addr_o !== 32'h0) begin
      fails++; $display("FAIL midrst_rom ce/addr got %b/%h exp 0/0", rom_ce_o, rom_addr_o);
    end
    chk_id("midrst_id", 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    idle_inputs(); rst = 1;
    step(); chk_pc("restart_pc0", 32'h0);
    step();
    chk_pc("restart_no_pend", 32'h4);
    chk_id("restart_id", 32'h0, rom_word(32'h0), 1'b1);
  endtask

  task automatic test_stall_id_hold();
    stall_if = 1; stall_id = 1;
    step();
    chk_pc("hold_pc", 32'h4);
    chk_id("hold_id", 32'h0, rom_word(32'h0), 1'b1);
    idle_inputs();
    step();
    chk_pc("hold_release_pc", 32'h8);
    chk_id("hold_release_id", 32'h4, rom_word(32'h4), 1'b1);
  endtask

`ifdef FETCH_ALIGN_CHECK_EN
  task automatic test_align();
    flush_i = 1; new_pc_i = 32'h182;
    step();
    idle_inputs();
    step();
    chk_id("adel_id", 32'h182, 32'h0, 1'b1);
    tests++;
    if (id_adel_o !== 1'b1) begin fails++; $display("FAIL adel_flag got %b exp 1", id_adel_o); end
  endtask
`endif

  initial begin
    test_reset();
    test_seq_fetch();
    test_branch_delay_slot();
    test_stall_pending();
    test_flush();
    test_wrap();
    test_reset_mid_stall();
    test_stall_id_hold();
`ifdef FETCH_ALIGN_CHECK_EN
    test_align();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
